// File: rtl/mem_arbiter_if.sv
// Memory-side command/response bus of the line-fill arbiter.
// master = arbiter issuing commands, slave = memory model/controller.
interface mem_arbiter_if #(
    parameter int ADDR_BITS = 10,
    parameter int LINE_BITS = 128
);
    logic                 M_req;
    logic                 M_we;
    logic [ADDR_BITS-1:0] M_addr;
    logic [LINE_BITS-1:0] M_wdata;
    logic                 M_ready;
    logic                 M_valid;
    logic [LINE_BITS-1:0] M_rdata;

    modport master (
        output M_req, M_we, M_addr, M_wdata,
        input  M_ready, M_valid, M_rdata
    );

    modport slave (
        input  M_req, M_we, M_addr, M_wdata,
        output M_ready, M_valid, M_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client (icache/dcache) line arbiter onto a single memory port.
// ARB_ROUND_ROBIN_EN: alternate grants on contention instead of dcache priority.
module mem_arbiter #(
    parameter int ADDR_BITS = 10,
    parameter int LINE_BITS = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 Ic_mem_req,
    input  logic [ADDR_BITS-1:0] Ic_mem_addr,
    output logic [LINE_BITS-1:0] F_mem_inst,
    output logic                 F_mem_valid,
    input  logic                 D_mem_req,
    input  logic                 D_mem_we,
    input  logic [ADDR_BITS-1:0] D_mem_addr,
    input  logic [LINE_BITS-1:0] D_mem_wdata,
    output logic [LINE_BITS-1:0] D_mem_rdata,
    output logic                 D_mem_valid,
    mem_arbiter_if.master        mem
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 any_req;
    logic                 grant_d;
    logic                 owner_d;
    logic                 we_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [LINE_BITS-1:0] wdata_q;
    logic [LINE_BITS-1:0] line_q;

    assign any_req = Ic_mem_req | D_mem_req;

`ifdef ARB_ROUND_ROBIN_EN
    // last_d = 1 when the dcache held the most recent grant
    logic last_d;

    assign grant_d = D_mem_req & (~Ic_mem_req | ~last_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d <= 1'b0;
        end else if (state == IDLE && any_req) begin
            last_d <= grant_d;
        end
    end
`else
    assign grant_d = D_mem_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        mem.M_req   = 1'b0;
        F_mem_valid = 1'b0;
        D_mem_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_req) state_nxt = REQ;
            end
            REQ: begin
                mem.M_req = 1'b1;
                if (mem.M_ready) state_nxt = WAIT;
            end
            WAIT: begin
                if (mem.M_valid) state_nxt = RESP;
            end
            RESP: begin
                F_mem_valid = ~owner_d;
                D_mem_valid = owner_d;
                state_nxt   = IDLE;
            end
        endcase
    end

    // Command fields are frozen at grant so requesters may change inputs freely
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_d <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            line_q  <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                owner_d <= grant_d;
                we_q    <= grant_d & D_mem_we;
                addr_q  <= grant_d ? D_mem_addr : Ic_mem_addr;
                wdata_q <= grant_d ? D_mem_wdata : '0;
            end
            if (state == WAIT && mem.M_valid) begin
                line_q <= mem.M_rdata;
            end
        end
    end

    assign mem.M_we    = we_q;
    assign mem.M_addr  = addr_q;
    assign mem.M_wdata = wdata_q;
    assign F_mem_inst  = line_q;
    assign D_mem_rdata = line_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Inputs and samples are taken on the falling clock edge.
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         Ic_mem_req;
    logic [9:0]   Ic_mem_addr;
    logic [127:0] F_mem_inst;
    logic         F_mem_valid;
    logic         D_mem_req;
    logic         D_mem_we;
    logic [9:0]   D_mem_addr;
    logic [127:0] D_mem_wdata;
    logic [127:0] D_mem_rdata;
    logic         D_mem_valid;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    localparam logic [127:0] LINE_A = {32{4'hA}};
    localparam logic [127:0] LINE_B = 128'h0BAD_F00D_CAFE_BEEF_1111_2222_3333_4444;
    localparam logic [127:0] LINE_C = 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC;
    localparam logic [127:0] WLINE  = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;

    mem_arbiter_if #(.ADDR_BITS(10), .LINE_BITS(128)) mem ();

    mem_arbiter #(.ADDR_BITS(10), .LINE_BITS(128)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Ic_mem_req  (Ic_mem_req),
        .Ic_mem_addr (Ic_mem_addr),
        .F_mem_inst  (F_mem_inst),
        .F_mem_valid (F_mem_valid),
        .D_mem_req   (D_mem_req),
        .D_mem_we    (D_mem_we),
        .D_mem_addr  (D_mem_addr),
        .D_mem_wdata (D_mem_wdata),
        .D_mem_rdata (D_mem_rdata),
        .D_mem_valid (D_mem_valid),
        .mem         (mem)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: waits for a command, accepts it after rdy_lo
    // stall cycles, answers vdly cycles after accept, returns at the
    // falling edge where the response pulse should be visible.
    task automatic serve(input int rdy_lo, input int vdly,
                         input logic [127:0] rdata,
                         output logic [9:0] a, output logic w,
                         output logic [127:0] wd, output int rc,
                         output bit stable, output int fc,
                         output int dc, output bit to);
        int n;
        to = 0; rc = 0; stable = 1; fc = 0; dc = 0;
        a = '0; w = 1'b0; wd = '0; n = 0;
        while (!mem.M_req && n < 20) begin
            @(negedge clk);
            n++;
            fc += int'(F_mem_valid);
            dc += int'(D_mem_valid);
        end
        if (!mem.M_req) begin
            to = 1;
            return;
        end
        a = mem.M_addr; w = mem.M_we; wd = mem.M_wdata; rc = 1;
        for (int i = 0; i < rdy_lo; i++) begin
            @(negedge clk);
            if (mem.M_req) rc++;
            if (mem.M_addr !== a || mem.M_we !== w || mem.M_wdata !== wd)
                stable = 0;
        end
        mem.M_ready = 1'b1;
        @(negedge clk);
        mem.M_ready = 1'b0;
        for (int i = 1; i < vdly; i++) begin
            @(negedge clk);
            fc += int'(F_mem_valid);
            dc += int'(D_mem_valid);
        end
        mem.M_rdata = rdata;
        mem.M_valid = 1'b1;
        @(negedge clk);
        mem.M_valid = 1'b0;
        fc += int'(F_mem_valid);
        dc += int'(D_mem_valid);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (mem.M_req !== 1'b0) begin errors++; $display("FAIL rst_m_req got %b want 0", mem.M_req); end
        checks++; if (mem.M_we !== 1'b0) begin errors++; $display("FAIL rst_m_we got %b want 0", mem.M_we); end
        checks++; if (mem.M_addr !== 10'h0) begin errors++; $display("FAIL rst_m_addr got %h want 000", mem.M_addr); end
        checks++; if (mem.M_wdata !== 128'h0) begin errors++; $display("FAIL rst_m_wdata got %h want 0", mem.M_wdata); end
        checks++; if (F_mem_valid !== 1'b0) begin errors++; $display("FAIL rst_f_valid got %b want 0", F_mem_valid); end
        checks++; if (D_mem_valid !== 1'b0) begin errors++; $display("FAIL rst_d_valid got %b want 0", D_mem_valid); end
        checks++; if (F_mem_inst !== 128'h0) begin errors++; $display("FAIL rst_f_inst got %h want 0", F_mem_inst); end
        checks++; if (D_mem_rdata !== 128'h0) begin errors++; $display("FAIL rst_d_rdata got %h want 0", D_mem_rdata); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (mem.M_req !== 1'b0) begin errors++; $display("FAIL idle_m_req got %b want 0", mem.M_req); end
    endtask

    task automatic test_icache();
        logic [9:0] a; logic w; logic [127:0] wd;
        int rc, fc, dc; bit st, to;
        Ic_mem_addr = 10'h005;
        Ic_mem_req  = 1'b1;
        serve(0, 2, LINE_A, a, w, wd, rc, st, fc, dc, to);
        Ic_mem_req = 1'b0;
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL ic_timeout got %b want 0", to); end
        checks++; if (a !== 10'h005) begin errors++; $display("FAIL ic_addr got %h want 005", a); end
        checks++; if (w !== 1'b0) begin errors++; $display("FAIL ic_we got %b want 0", w); end
        checks++; if (fc !== 1) begin errors++; $display("FAIL ic_f_pulses got %0d want 1", fc); end
        checks++; if (dc !== 0) begin errors++; $display("FAIL ic_d_pulses got %0d want 0", dc); end
        checks++; if (F_mem_inst !== LINE_A) begin errors++; $display("FAIL ic_inst got %h want %h", F_mem_inst, LINE_A); end
        @(negedge clk);
        checks++; if (F_mem_valid !== 1'b0) begin errors++; $display("FAIL ic_pulse_len got %b want 0", F_mem_valid); end
    endtask

    task automatic test_min_latency();
        logic [9:0] a; logic w; logic [127:0] wd;
        int rc, fc, dc, t0; bit st, to;
        Ic_mem_addr = 10'h00C;
        Ic_mem_req  = 1'b1;
        t0 = cyc;
        serve(0, 1, LINE_B, a, w, wd, rc, st, fc, dc, to);
        Ic_mem_req = 1'b0;
        // edges IDLE->REQ->WAIT->RESP: valid shows in the 4th cycle
        checks++; if (cyc - t0 !== 3) begin errors++; $display("FAIL lat_edges got %0d want 3", cyc - t0); end
        checks++; if (F_mem_valid !== 1'b1) begin errors++; $display("FAIL lat_f_valid got %b want 1", F_mem_valid); end
        checks++; if (F_mem_inst !== LINE_B) begin errors++; $display("FAIL lat_inst got %h want %h", F_mem_inst, LINE_B); end
        @(negedge clk);
    endtask

    task automatic test_priority();
        logic [9:0] a; logic w; logic [127:0] wd;
        int rc, fc, dc; bit st, to;
        Ic_mem_addr = 10'h010;
        D_mem_addr  = 10'h020;
        D_mem_we    = 1'b0;
        Ic_mem_req  = 1'b1;
        D_mem_req   = 1'b1;
        serve(0, 1, LINE_B, a, w, wd, rc, st, fc, dc, to);
        D_mem_req = 1'b0;
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL pri1_timeout got %b want 0", to); end
        checks++; if (a !== 10'h020) begin errors++; $display("FAIL pri1_addr got %h want 020", a); end
        checks++; if (dc !== 1 || fc !== 0) begin errors++; $display("FAIL pri1_pulses got d=%0d f=%0d want d=1 f=0", dc, fc); end
        checks++; if (D_mem_rdata !== LINE_B) begin errors++; $display("FAIL pri1_rdata got %h want %h", D_mem_rdata, LINE_B); end
        serve(0, 1, LINE_C, a, w, wd, rc, st, fc, dc, to);
        Ic_mem_req = 1'b0;
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL pri2_timeout got %b want 0", to); end
        checks++; if (a !== 10'h010) begin errors++; $display("FAIL pri2_addr got %h want 010", a); end
        checks++; if (fc !== 1 || dc !== 0) begin errors++; $display("FAIL pri2_pulses got f=%0d d=%0d want f=1 d=0", fc, dc); end
        checks++; if (F_mem_inst !== LINE_C) begin errors++; $display("FAIL pri2_inst got %h want %h", F_mem_inst, LINE_C); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [9:0] a; logic w; logic [127:0] wd;
        int rc, fc, dc; bit st, to;
        logic [9:0] exp_a [4];
`ifdef ARB_ROUND_ROBIN_EN
        exp_a = '{10'h020, 10'h010, 10'h020, 10'h010};
`else
        exp_a = '{10'h020, 10'h020, 10'h020, 10'h020};
`endif
        Ic_mem_addr = 10'h010;
        D_mem_addr  = 10'h020;
        D_mem_we    = 1'b0;
        Ic_mem_req  = 1'b1;
        D_mem_req   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            serve(0, 1, LINE_A, a, w, wd, rc, st, fc, dc, to);
            checks++;
            if (to !== 1'b0 || a !== exp_a[i]) begin
                errors++;
                $display("FAIL b2b_grant%0d got %h (to=%b) want %h", i, a, to, exp_a[i]);
            end
        end
        Ic_mem_req = 1'b0;
        D_mem_req  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        logic [9:0] a; logic w; logic [127:0] wd;
        int rc, fc, dc; bit st, to;
        D_mem_addr  = 10'h3FF;
        D_mem_wdata = WLINE;
        D_mem_we    = 1'b1;
        D_mem_req   = 1'b1;
        @(negedge clk);
        D_mem_addr  = 10'h155;
        D_mem_wdata = '0;
        D_mem_we    = 1'b0;
        serve(3, 1, LINE_C, a, w, wd, rc, st, fc, dc, to);
        D_mem_req = 1'b0;
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL wr_timeout got %b want 0", to); end
        checks++; if (a !== 10'h3FF) begin errors++; $display("FAIL wr_addr got %h want 3ff", a); end
        checks++; if (w !== 1'b1) begin errors++; $display("FAIL wr_we got %b want 1", w); end
        checks++; if (wd !== WLINE) begin errors++; $display("FAIL wr_wdata got %h want %h", wd, WLINE); end
        checks++; if (rc !== 4) begin errors++; $display("FAIL wr_req_cycles got %0d want 4", rc); end
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL wr_stable got %b want 1", st); end
        checks++; if (dc !== 1 || fc !== 0) begin errors++; $display("FAIL wr_pulses got d=%0d f=%0d want d=1 f=0", dc, fc); end
        @(negedge clk);
        checks++; if (D_mem_valid !== 1'b0) begin errors++; $display("FAIL wr_pulse_len got %b want 0", D_mem_valid); end
    endtask

    task automatic test_reset_mid();
        int n, vc;
        Ic_mem_addr = 10'h033;
        Ic_mem_req  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!mem.M_req && n < 20) begin @(negedge clk); n++; end
        checks++; if (mem.M_req !== 1'b1) begin errors++; $display("FAIL rm_req got %b want 1", mem.M_req); end
        mem.M_ready = 1'b1;
        @(negedge clk);
        mem.M_ready = 1'b0;
        Ic_mem_req  = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (mem.M_addr !== 10'h0) begin errors++; $display("FAIL rm_async_addr got %h want 000", mem.M_addr); end
        checks++; if (F_mem_inst !== 128'h0) begin errors++; $display("FAIL rm_async_inst got %h want 0", F_mem_inst); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem.M_rdata = LINE_B;
        mem.M_valid = 1'b1;
        @(negedge clk);
        mem.M_valid = 1'b0;
        vc = 0;
        for (int i = 0; i < 3; i++) begin
            vc += int'(F_mem_valid) + int'(D_mem_valid) + int'(mem.M_req);
            @(negedge clk);
        end
        checks++; if (vc !== 0) begin errors++; $display("FAIL rm_late_valid got %0d activity want 0", vc); end
        checks++; if (F_mem_inst !== 128'h0 || D_mem_rdata !== 128'h0) begin errors++; $display("FAIL rm_line got %h want 0", F_mem_inst); end
        checks++; if (mem.M_addr !== 10'h0 || mem.M_we !== 1'b0) begin errors++; $display("FAIL rm_cmd got %h/%b want 000/0", mem.M_addr, mem.M_we); end
    endtask

    task automatic test_spurious();
        logic [9:0] a; logic w; logic [127:0] wd;
        int rc, fc, dc, vc; bit st, to;
        mem.M_rdata = LINE_C;
        mem.M_valid = 1'b1;
        @(negedge clk);
        mem.M_valid = 1'b0;
        vc = 0;
        for (int i = 0; i < 2; i++) begin
            vc += int'(F_mem_valid) + int'(D_mem_valid) + int'(mem.M_req);
            @(negedge clk);
        end
        checks++; if (vc !== 0) begin errors++; $display("FAIL sp_activity got %0d want 0", vc); end
        checks++; if (F_mem_inst !== 128'h0) begin errors++; $display("FAIL sp_line got %h want 0", F_mem_inst); end
        Ic_mem_addr = 10'h077;
        Ic_mem_req  = 1'b1;
        @(negedge clk);
        checks++; if (mem.M_req !== 1'b1) begin errors++; $display("FAIL sp_idle_grant got %b want 1", mem.M_req); end
        serve(0, 1, LINE_A, a, w, wd, rc, st, fc, dc, to);
        Ic_mem_req = 1'b0;
        checks++; if (to !== 1'b0 || a !== 10'h077 || fc !== 1) begin errors++; $display("FAIL sp_txn got addr %h f=%0d want 077 f=1", a, fc); end
        checks++; if (F_mem_inst !== LINE_A) begin errors++; $display("FAIL sp_inst got %h want %h", F_mem_inst, LINE_A); end
        @(negedge clk);
    endtask

    initial begin
        Ic_mem_req  = 1'b0;
        Ic_mem_addr = '0;
        D_mem_req   = 1'b0;
        D_mem_we    = 1'b0;
        D_mem_addr  = '0;
        D_mem_wdata = '0;
        mem.M_ready = 1'b0;
        mem.M_valid = 1'b0;
        mem.M_rdata = '0;
        test_reset();
        test_icache();
        test_min_latency();
        test_priority();
        test_back_to_back();
        test_write();
        test_reset_mid();
        test_spurious();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_BITS, default 10, line-address width for all ports.
REQ-002 Parameter: LINE_BITS, default 128, line data width for all ports.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  in  1  sole clock, all state updates on rising edge.
REQ-005 Port: rst_n  in  1  asynchronous active-low reset.
REQ-006 Port: Ic_mem_req  in  1  icache line-fill request, held until served.
REQ-007 Port: Ic_mem_addr  in  ADDR_BITS  icache line index.
REQ-008 Port: F_mem_inst  out  LINE_BITS  fill line returned to icache.
REQ-009 Port: F_mem_valid  out  1  one-cycle pulse, F_mem_inst valid.
REQ-010 Port: D_mem_req  in  1  dcache request, held until served.
REQ-011 Port: D_mem_we  in  1  1 = line write, 0 = line read.
REQ-012 Port: D_mem_addr  in  ADDR_BITS  dcache line index.
REQ-013 Port: D_mem_wdata  in  LINE_BITS  write line.
REQ-014 Port: D_mem_rdata  out  LINE_BITS  read line returned to dcache.
REQ-015 Port: D_mem_valid  out  1  one-cycle pulse, read data valid or write done.
REQ-016 Port: M_req, M_we  out  1 each  memory command valid, write flag.
REQ-017 Port: M_addr  out  ADDR_BITS; M_wdata  out  LINE_BITS  memory command fields.
REQ-018 Port: M_ready  in  1  memory accepts command when M_req and M_ready both high.
REQ-019 Port: M_valid  in  1  one-cycle completion pulse; M_rdata  in  LINE_BITS.

Function
REQ-020 FSM states SHALL be IDLE, REQ, WAIT, RESP; one transaction in flight at a time.
REQ-021 IDLE: with any request high, latch owner, addr, we (0 for icache), wdata; go to REQ next edge.
REQ-022 Both requests high in IDLE: dcache SHALL win (priority mode, see REQ-034).
REQ-023 REQ: M_req=1 with latched fields; stay in REQ until M_ready=1, then go to WAIT.
REQ-024 WAIT: on M_valid, capture M_rdata into line register, go to RESP; M_valid outside WAIT SHALL be ignored.
REQ-025 RESP: pulse owner's *_valid for exactly one cycle with captured line on its data port; go to IDLE.
REQ-026 Write transactions SHALL still wait for M_valid; D_mem_valid then acts as write acknowledge; D_mem_rdata undefined-but-stable.
REQ-027 In RESP the arbiter SHALL NOT sample requests (requester deasserts while valid is high); earliest re-grant is the IDLE cycle after.
REQ-028 Minimum latency request-to-valid: 4 cycles (IDLE, REQ, WAIT with M_ready and M_valid immediate, RESP).
REQ-029 All outputs SHALL be registered or decoded from FSM state only; no combinational path from request inputs to M_* outputs.
REQ-030 Non-owner valid SHALL stay 0 throughout; inputs changing after latch SHALL NOT affect the in-flight command.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, clear latched owner, addr, wdata and line register, and reset the round-robin pointer to "icache last".
REQ-032 Outputs during/after reset: M_req=0, M_we=0, M_addr=0, M_wdata=0, F_mem_valid=0, D_mem_valid=0, F_mem_inst=0, D_mem_rdata=0.
REQ-033 Reset mid-transaction SHALL abandon the transaction; a late M_valid after reset release SHALL be ignored (state is IDLE).

Configuration
REQ-034 Macro ARB_ROUND_ROBIN_EN: when defined, simultaneous requests grant the requester not served last (pointer updates on each grant); when undefined, fixed dcache priority per REQ-022 and no pointer register.

Verification
REQ-035 Icache only, addr 0x005, M_ready=1, M_valid 2 cycles after accept with data 0xA..A -> F_mem_valid one pulse, F_mem_inst=0xA..A, D_mem_valid=0.
REQ-036 Both request same cycle (I addr 0x010, D read addr 0x020), macro undefined -> M_addr 0x020 first, then 0x010 with D_mem_valid preceding F_mem_valid.
REQ-037 Same as REQ-036 with ARB_ROUND_ROBIN_EN, requests held repeatedly -> grants alternate D, I, D, I.
REQ-038 D write addr 0x3FF, wdata 0x1234..., M_ready low 3 cycles -> M_req held 4 cycles with stable fields, M_we=1; one D_mem_valid pulse after M_valid.
REQ-039 rst_n low during WAIT, M_valid pulse 1 cycle after release -> no *_valid pulse, FSM IDLE, all outputs 0.
REQ-040 Spurious M_valid while IDLE -> no valid pulse, no state change.
